// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: segment-width helper, parameter legality check and full-adder cell
// functions shared by pipe_add and pipe_add_stage.
package pipe_add_pkg;

  function automatic int seg_width(input int width, input int stages);
    if (stages > 0) begin
      return width / stages;
    end else begin
      return width;
    end
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (ci & (x ^ y));
  endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// pipe_add_stage: combinational SEG-bit ripple-carry segment built from full-adder cells.
module pipe_add_stage
  import pipe_add_pkg::*;
#(
  parameter int SEG = 5
) (
  input  logic [SEG-1:0] seg_a,
  input  logic [SEG-1:0] seg_b,
  input  logic           c_in,
  output logic [SEG-1:0] seg_sum,
  output logic           c_out
);

  logic carry_s;

  // Ripple the carry through one full-adder cell per bit
  always_comb begin
    carry_s = c_in;
    seg_sum = {SEG{1'b0}};
    for (int i = 0; i < SEG; i++) begin
      seg_sum[i] = fa_sum(seg_a[i], seg_b[i], carry_s);
      carry_s    = fa_carry(seg_a[i], seg_b[i], carry_s);
    end
    c_out = carry_s;
  end

endmodule

// File: rtl/pipe_add.sv
// pipe_add: pipelined WIDTH-bit adder, one SEG-bit segment per stage, valid/ready on both sides.
// Optional subtract mode (adds the sub port) when PIPE_ADD_SUB_EN is defined.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_add: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic [STAGES-1:0] v_s;
  logic [STAGES-1:0] en_s;
  logic              run_s;
  logic [WIDTH-1:0]  b_eff_s;
  logic              c0_s;

  // Effective B operand and first-segment carry
  always_comb begin
    b_eff_s = b;
    c0_s    = cin;
`ifdef PIPE_ADD_SUB_EN
    if (sub) begin
      b_eff_s = ~b;
      c0_s    = 1'b1;
    end else begin
      b_eff_s = b;
      c0_s    = cin;
    end
`endif
  end

  // Enable chain: a stage advances when it is empty or the stage after it advances
  always_comb begin
    en_s           = {STAGES{1'b0}};
    run_s          = !v_s[STAGES-1] || out_ready;
    en_s[STAGES-1] = run_s;
    for (int k = STAGES - 2; k >= 0; k--) begin
      run_s   = !v_s[k] || run_s;
      en_s[k] = run_s;
    end
  end

  assign in_ready = en_s[0] && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // REM: operand bits not yet consumed (this segment upward); LO: result bits finished here
    localparam int REM = WIDTH - k * SEG;
    localparam int LO  = (k + 1) * SEG;

    logic [REM-1:0] cur_a_s;
    logic [REM-1:0] cur_b_s;
    logic           cur_c_s;
    logic           cur_v_s;
    logic [SEG-1:0] seg_sum_s;
    logic           seg_c_s;
    logic [LO-1:0]  nxt_sum_s;
    logic           v_r;
    logic           c_r;
    logic [LO-1:0]  sum_r;

    if (k == 0) begin : g_src
      assign cur_a_s   = a;
      assign cur_b_s   = b_eff_s;
      assign cur_c_s   = c0_s;
      assign cur_v_s   = in_valid && in_ready;
      assign nxt_sum_s = seg_sum_s;
    end else begin : g_src
      assign cur_a_s   = g_stage[k-1].g_skew.op_a_r;
      assign cur_b_s   = g_stage[k-1].g_skew.op_b_r;
      assign cur_c_s   = g_stage[k-1].c_r;
      assign cur_v_s   = g_stage[k-1].v_r;
      assign nxt_sum_s = {seg_sum_s, g_stage[k-1].sum_r};
    end

    pipe_add_stage #(.SEG(SEG)) u_seg (
      .seg_a   (cur_a_s[SEG-1:0]),
      .seg_b   (cur_b_s[SEG-1:0]),
      .c_in    (cur_c_s),
      .seg_sum (seg_sum_s),
      .c_out   (seg_c_s)
    );

    assign v_s[k] = v_r;

    // Stage valid, segment carry and completed low result bits
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= {LO{1'b0}};
      end else if (en_s[k]) begin
        v_r   <= cur_v_s;
        c_r   <= seg_c_s;
        sum_r <= nxt_sum_s;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM-SEG-1:0] op_a_r;
      logic [REM-SEG-1:0] op_b_r;

      // Carry the unconsumed upper operand segments forward
      always_ff @(posedge clk) begin
        if (rst) begin
          op_a_r <= {(REM-SEG){1'b0}};
          op_b_r <= {(REM-SEG){1'b0}};
        end else if (en_s[k]) begin
          op_a_r <= cur_a_s[REM-1:SEG];
          op_b_r <= cur_b_s[REM-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_r;

      // Signed overflow from the operand and result sign bits of the final segment
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (en_s[k]) begin
          ovf_r <= (cur_a_s[SEG-1] == cur_b_s[SEG-1]) && (seg_sum_s[SEG-1] != cur_a_s[SEG-1]);
        end
      end
    end
  end

  assign out_valid = v_s[STAGES-1];
  assign sum       = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].c_r;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: directed self-checking bench for pipe_add (WIDTH=20, STAGES=4).
// Define PIPE_ADD_SUB_EN for both RTL and bench to also exercise subtract mode.
module tb_pipe_add;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef PIPE_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_add #(.WIDTH(20), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = cc;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 20'h00000, 20'h00000, 1'b0);
`ifdef PIPE_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (sum !== 20'h00000) begin bad++; $display("FAIL reset_sum got=%h want=00000", sum); end
    total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {cout, ovf}); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_carry();
    int           lat;
    logic [W-1:0] s_got;
    logic         c_got;
    logic         o_got;
    lat   = 0;
    s_got = 20'h00000;
    c_got = 1'b0;
    o_got = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 20'h7FFFF, 20'h00001, 1'b0);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL carry_accept got=%b want=1", in_ready); end
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      drive(1'b0, 20'h00000, 20'h00000, 1'b0);
      #1;
      if (out_valid === 1'b1) begin
        lat   = i;
        s_got = sum;
        c_got = cout;
        o_got = ovf;
        break;
      end
    end
    total++; if (lat != 4) begin bad++; $display("FAIL carry_latency got=%0d want=4", lat); end
    total++; if (s_got !== 20'h80000) begin bad++; $display("FAIL carry_sum got=%h want=80000", s_got); end
    total++; if (c_got !== 1'b0) begin bad++; $display("FAIL carry_cout got=%b want=0", c_got); end
    total++; if (o_got !== 1'b1) begin bad++; $display("FAIL carry_ovf got=%b want=1", o_got); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W-1:0] es [3];
    logic         ec [3];
    logic         eo [3];
    int           n;
    int           first;
    va = '{20'h55555, 20'hFFFFF, 20'h00000};
    vb = '{20'h55555, 20'h00001, 20'h00000};
    vc = '{1'b0, 1'b0, 1'b1};
    es = '{20'hAAAAA, 20'h00000, 20'h00001};
    ec = '{1'b0, 1'b1, 1'b0};
    eo = '{1'b1, 1'b0, 1'b0};
    n     = 0;
    first = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (cyc < 3) drive(1'b1, va[cyc], vb[cyc], vc[cyc]);
      else         drive(1'b0, 20'h00000, 20'h00000, 1'b0);
      #1;
      if (cyc == 0) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_out_valid got=%b want=0", out_valid); end
      end
      if (cyc < 3) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, in_ready); end
      end
      if (out_valid === 1'b1) begin
        if (n < 3) begin
          total++; if (sum !== es[n]) begin bad++; $display("FAIL b2b_sum idx=%0d got=%h want=%h", n, sum, es[n]); end
          total++; if (cout !== ec[n]) begin bad++; $display("FAIL b2b_cout idx=%0d got=%b want=%b", n, cout, ec[n]); end
          total++; if (ovf !== eo[n]) begin bad++; $display("FAIL b2b_ovf idx=%0d got=%b want=%b", n, ovf, eo[n]); end
          if (n == 0) begin
            first = cyc;
            total++; if (cyc != 4) begin bad++; $display("FAIL b2b_latency got=%0d want=4", cyc); end
          end else begin
            total++; if (cyc != first + n) begin bad++; $display("FAIL b2b_consecutive idx=%0d got=%0d want=%0d", n, cyc, first + n); end
          end
        end
        n++;
      end
    end
    total++; if (n != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", n); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] va [6];
    logic [W-1:0] vb [6];
    logic         vc [6];
    logic [W-1:0] es [6];
    logic         ec [6];
    logic         eo [6];
    int           j;
    int           n;
    va = '{20'h00001, 20'h12345, 20'hFFFFF, 20'h80000, 20'h0F0F0, 20'h40000};
    vb = '{20'h00002, 20'h11111, 20'hFFFFF, 20'h80000, 20'h00F0F, 20'h40000};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    es = '{20'h00003, 20'h23456, 20'hFFFFF, 20'h00000, 20'h10000, 20'h80000};
    ec = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    eo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    j = 0;
    n = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (j < 6) drive(1'b1, va[j], vb[j], vc[j]);
      else       drive(1'b0, 20'h00000, 20'h00000, 1'b0);
      #1;
      if (in_valid && in_ready) j++;
    end
    @(negedge clk);
    if (j < 6) drive(1'b1, va[j], vb[j], vc[j]);
    #1;
    total++; if (j != 4) begin bad++; $display("FAIL bp_accepted got=%0d want=4", j); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", out_valid); end
    total++; if ({sum, cout, ovf} !== {es[0], ec[0], eo[0]}) begin bad++; $display("FAIL bp_hold_data got=%h/%b/%b want=%h/%b/%b", sum, cout, ovf, es[0], ec[0], eo[0]); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (j < 6) drive(1'b1, va[j], vb[j], vc[j]);
        else       drive(1'b0, 20'h00000, 20'h00000, 1'b0);
      end
      #1;
      if (cyc == 0) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_full_release_in_ready got=%b want=1", in_ready); end
      end
      if (out_valid === 1'b1) begin
        if (n < 6) begin
          total++; if ({sum, cout, ovf} !== {es[n], ec[n], eo[n]}) begin bad++; $display("FAIL bp_drain idx=%0d got=%h/%b/%b want=%h/%b/%b", n, sum, cout, ovf, es[n], ec[n], eo[n]); end
        end
        n++;
      end
      if (in_valid && in_ready) j++;
    end
    total++; if (n != 6) begin bad++; $display("FAIL bp_result_count got=%0d want=6", n); end
    total++; if (j != 6) begin bad++; $display("FAIL bp_accept_count got=%0d want=6", j); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 20'h11111, 20'h22222, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 20'h33333, 20'h44444, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 20'h00000, 20'h00000, 1'b0);
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_ghost_results got=%0d want=0", seen); end
  endtask

`ifdef PIPE_ADD_SUB_EN
  task automatic test_sub();
    logic [W-1:0] va [2];
    logic [W-1:0] vb [2];
    logic         vc [2];
    logic [W-1:0] es [2];
    logic         ec [2];
    logic         eo [2];
    int           n;
    va = '{20'h00005, 20'h80000};
    vb = '{20'h00007, 20'h00001};
    vc = '{1'b1, 1'b0};
    es = '{20'hFFFFE, 20'h7FFFF};
    ec = '{1'b0, 1'b1};
    eo = '{1'b0, 1'b1};
    n = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc < 2) begin
        drive(1'b1, va[cyc], vb[cyc], vc[cyc]);
        sub = 1'b1;
      end else begin
        drive(1'b0, 20'h00000, 20'h00000, 1'b0);
        sub = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        if (n < 2) begin
          total++; if ({sum, cout, ovf} !== {es[n], ec[n], eo[n]}) begin bad++; $display("FAIL sub_result idx=%0d got=%h/%b/%b want=%h/%b/%b", n, sum, cout, ovf, es[n], ec[n], eo[n]); end
        end
        n++;
      end
    end
    total++; if (n != 2) begin bad++; $display("FAIL sub_count got=%0d want=2", n); end
  endtask
`endif

  initial begin
    test_reset();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef PIPE_ADD_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_add.md
# pipe_add

Parametrised, pipelined two-operand adder with a valid/ready handshake on both sides. It generalises the fixed 20-bit ripple adder: operand width and pipeline depth are parameters, and it provides carry-in, carry-out and signed-overflow flags. It sits between a producer and consumer of operand pairs in the datapath, sustains one addition per cycle, and tolerates downstream backpressure without losing or duplicating results.

## Interface
- WIDTH, 20, operand/result width in bits; WIDTH % STAGES == 0 is required.
- STAGES, 4, number of pipeline stages, 1..WIDTH; each stage adds one WIDTH/STAGES-bit segment.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present on a/b/cin.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- out_valid  output  1  result present on sum/cout/ovf.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow.
- sub  input  1  present only with PIPE_ADD_SUB_EN; see Configuration.

## Operation
- SEG = WIDTH/STAGES. Stage k (0 = first) adds bits [k*SEG +: SEG] of A and B, plus the carry registered from stage k-1 (stage 0 uses cin).
- Unconsumed upper operand segments are skewed forward through the stage registers. Completed lower sum segments are delayed so that all segments of one result leave together.
- Each stage holds one valid bit v[k].
- Enables: en[STAGES-1] = !v[STAGES-1] || out_ready; en[k] = !v[k] || en[k+1]; in_ready = en[0] && !rst.
- A stage loads only when its enable is high. v[k] takes v[k-1] (for stage 0: in_valid && in_ready).
- Bubbles collapse: an empty stage always accepts, even while the output is stalled.
- out_valid = v[STAGES-1]. sum, cout and ovf come directly from the last stage's registers.
- ovf = (A[WIDTH-1] == B'[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]), where B' is the effective B operand.
- Results emerge in acceptance order. There is no reordering, dropping or duplication.

## Timing
- Reset: all v[k] = 0. All data registers = 0. Therefore out_valid = 0, sum = 0, cout = 0, ovf = 0. in_ready = 0 while rst is high and 1 in the first cycle after release.
- Inputs are sampled on the rising edge where in_valid && in_ready.
- Latency with no stalls: the result is valid exactly STAGES cycles after the accepting edge. Throughput is 1 result per cycle.
- Output hold: while out_valid && !out_ready, sum/cout/ovf are stable and out_valid stays 1.
- Capacity: STAGES results in flight. When all stages are full and out_ready = 0, in_ready = 0.
- Full pipeline with out_ready = 1: a new input is accepted on the same edge the last result leaves.
- in_ready depends combinationally on out_ready, through the enable chain only. in_valid does not feed in_ready.
- Reset mid-operation: all in-flight operations are discarded. out_valid = 0 from the cycle after the reset edge, and discarded results never appear.
- STAGES = 1 degenerates to a single registered adder with latency 1.

## Configuration
- PIPE_ADD_SUB_EN defined: the sub port exists and is sampled with the operands.
  - sub = 1 gives B' = ~b, and the stage-0 carry-in is forced to 1 (cin is ignored). The result is a - b, with cout = 1 meaning no borrow.
  - sub = 0 gives B' = b and uses cin.
- PIPE_ADD_SUB_EN undefined: no sub port, B' = b, add only.

## Structure
- Package pipe_add_pkg holds the SEG width helper function and the parameter legality checks: WIDTH % STAGES == 0 and 1 <= STAGES <= WIDTH. A failed check is an elaboration error.
- Sub-module pipe_add_stage is one combinational SEG-bit ripple segment: seg_a, seg_b, c_in -> seg_sum, c_out, built from full-adder cells. The top module holds all registers and the handshake logic.

## Test plan
All scenarios use WIDTH = 20, STAGES = 4.
- Reset: rst high 2 cycles -> out_valid = 0, sum = 0x00000, in_ready = 0; first cycle after release -> in_ready = 1.
- Carry across a segment boundary: a = 0x7FFFF, b = 0x00001, cin = 0 accepted at edge t -> out_valid at t+4, sum = 0x80000, cout = 0, ovf = 1.
- Back-to-back with out_ready = 1: vectors 0x55555+0x55555, 0xFFFFF+0x00001, 0x00000+0x00000 with cin = 1 -> consecutive results, in order:
  - 0xAAAAA, ovf = 1
  - 0x00000, cout = 1, ovf = 0
  - 0x00001, cout = 0
- Backpressure: out_ready = 0 while 6 vectors are offered -> exactly 4 accepted, then in_ready = 0 and the output stays stable. Releasing out_ready drains all 4 in order, then the remaining 2, with none lost or duplicated.
- Reset mid-flight: 2 operations in flight, 1-cycle rst pulse -> out_valid = 0 the next cycle, and neither result ever appears.
- PIPE_ADD_SUB_EN: sub = 1, a = 0x00005, b = 0x00007 -> sum = 0xFFFFE, cout = 0, ovf = 0. Then sub = 1, a = 0x80000, b = 0x00001 -> sum = 0x7FFFF, cout = 1, ovf = 1.
